// File: rtl/manual_drive_ctrl_if.sv
// Bundles the driver controls and the status outputs of manual_drive_ctrl.
//   master : drives en/power/clutch/brake/throttle/rgs/left/right, reads status
//   slave  : the controller side (manual_drive_ctrl)
//   Status : state[1:0], moving_state[3:0], power_off, turn_left_light,
//            turn_right_light, mileage[MILE_W-1:0]
interface manual_drive_ctrl_if #(
    parameter int MILE_W = 16
);
    logic              en;
    logic              power;
    logic              clutch;
    logic              brake;
    logic              throttle;
    logic              rgs;
    logic              left;
    logic              right;
    logic [1:0]        state;
    logic [3:0]        moving_state;
    logic              power_off;
    logic              turn_left_light;
    logic              turn_right_light;
    logic [MILE_W-1:0] mileage;

    modport master (
        output en, power, clutch, brake, throttle, rgs, left, right,
        input  state, moving_state, power_off, turn_left_light,
               turn_right_light, mileage
    );

    modport slave (
        input  en, power, clutch, brake, throttle, rgs, left, right,
        output state, moving_state, power_off, turn_left_light,
               turn_right_light, mileage
    );
endinterface

// File: rtl/manual_drive_ctrl.sv
// Manual-mode drive controller: run-state FSM (NSTART/START/MOVING), motion
// direction, power-off request pulse, blinking turn lights and odometer.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : manual_drive_ctrl_if.slave (driver controls in, status out)
// All outputs are registered; inputs sampled at an edge act at that edge.
module manual_drive_ctrl #(
    parameter int MILE_W    = 16,
    parameter int TICK_DIV  = 100000000,
    parameter int BLINK_DIV = 50000000,
    parameter int REV_EN    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    manual_drive_ctrl_if.slave   bus
);
    localparam logic [1:0] NSTART = 2'b00;
    localparam logic [1:0] START  = 2'b01;
    localparam logic [1:0] MOVING = 2'b10;

    localparam logic [3:0] NON_MOVING   = 4'b0000;
    localparam logic [3:0] MOVE_FORWARD = 4'b0001;
    localparam logic [3:0] MOVE_BACK    = 4'b0010;
    localparam logic [3:0] TURN_LEFT    = 4'b0100;
    localparam logic [3:0] TURN_RIGHT   = 4'b1000;

    localparam int TICK_W  = $clog2(TICK_DIV + 1);
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);

    logic [1:0]         state_q, state_d;
    logic [3:0]         moving_q, moving_d, dir;
    logic               power_off_q, power_off_d;
    logic               clear_mile;
    logic               left_light_q, right_light_q;
    logic               req_left, req_right;
    logic [MILE_W-1:0]  mileage_q;
    logic [TICK_W-1:0]  tick_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               phase_q, phase_d;
    logic               active, blink_wrap, tick_en, tick_wrap;

    assign active     = bus.en & bus.power;
    assign blink_wrap = (blink_cnt == BLINK_W'(BLINK_DIV - 1));
    assign phase_d    = phase_q ^ blink_wrap;
    // Odometer advances only while really driving; dropping en/power freezes it.
    assign tick_en    = active && (state_q == MOVING);
    assign tick_wrap  = tick_en && (tick_cnt == TICK_W'(TICK_DIV - 1));

    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        moving_d    = moving_q;
        power_off_d = 1'b0;
        clear_mile  = 1'b0;
        req_left    = 1'b0;
        req_right   = 1'b0;

        dir = MOVE_FORWARD;
        if (bus.left && !bus.right)      dir = TURN_LEFT;
        else if (bus.right && !bus.left) dir = TURN_RIGHT;

        if (!active) begin
            state_d  = NSTART;
            moving_d = NON_MOVING;
        end else begin
            case (state_q)
                NSTART: begin
                    moving_d = NON_MOVING;
                    if (!bus.brake) begin
                        if (bus.throttle && !bus.clutch) begin
                            // Throttle without clutch from standstill: stall.
                            power_off_d = 1'b1;
                            clear_mile  = 1'b1;
                        end else if (bus.throttle && bus.clutch && !bus.rgs) begin
                            state_d = START;
                        end
                    end
                end
                START: begin
                    moving_d = NON_MOVING;
                    if (bus.brake) begin
                        state_d = NSTART;
                    end else if (bus.throttle && !bus.clutch && bus.rgs) begin
                        if (REV_EN != 0) begin
                            state_d  = MOVING;
                            moving_d = MOVE_BACK;
                        end
                    end else if (bus.throttle && !bus.clutch) begin
                        state_d  = MOVING;
                        moving_d = dir;
                    end
                end
                MOVING: begin
                    if (bus.rgs && !bus.clutch) begin
                        // Reverse engaged without clutch while moving: stall,
                        // but the odometer keeps its count.
                        state_d     = NSTART;
                        moving_d    = NON_MOVING;
                        power_off_d = 1'b1;
                    end else if (bus.brake) begin
                        state_d  = NSTART;
                        moving_d = NON_MOVING;
                    end else if (!bus.throttle) begin
                        state_d  = START;
                        moving_d = NON_MOVING;
                    end else if (bus.rgs) begin
                        if (REV_EN != 0) moving_d = MOVE_BACK;
                    end else begin
                        moving_d = dir;
                    end
                end
                default: begin
                    state_d  = NSTART;
                    moving_d = NON_MOVING;
                end
            endcase

            // Lamp request follows the state being entered this edge.
            if (state_d == NSTART) begin
                req_left  = 1'b1;
                req_right = 1'b1;
            end else if (moving_d != MOVE_BACK) begin
                req_left  = bus.left;
                req_right = bus.right;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= NSTART;
            moving_q      <= NON_MOVING;
            power_off_q   <= 1'b0;
            left_light_q  <= 1'b0;
            right_light_q <= 1'b0;
            mileage_q     <= '0;
            tick_cnt      <= '0;
            blink_cnt     <= '0;
            phase_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            moving_q      <= moving_d;
            power_off_q   <= power_off_d;
            left_light_q  <= req_left & phase_d;
            right_light_q <= req_right & phase_d;
            phase_q       <= phase_d;
            blink_cnt     <= blink_wrap ? '0 : blink_cnt + 1'b1;

            // A stall clear takes priority over an odometer tick.
            if (clear_mile) begin
                tick_cnt  <= '0;
                mileage_q <= '0;
            end else if (tick_en) begin
                if (tick_wrap) begin
                    tick_cnt  <= '0;
                    mileage_q <= mileage_q + 1'b1;
                end else begin
                    tick_cnt  <= tick_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.state            = state_q;
    assign bus.moving_state     = moving_q;
    assign bus.power_off        = power_off_q;
    assign bus.turn_left_light  = left_light_q;
    assign bus.turn_right_light = right_light_q;
    assign bus.mileage          = mileage_q;
endmodule

// File: tb/tb_manual_drive_ctrl.sv
// Directed bench for manual_drive_ctrl (MILE_W=4, TICK_DIV=4, BLINK_DIV=2),
// plus a second instance built with REV_EN=0.
module tb_manual_drive_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   k      = 0;   // edges since reset release, drives the blink-phase model

    always #5 clk = ~clk;

    manual_drive_ctrl_if #(.MILE_W(4)) bus ();
    manual_drive_ctrl_if #(.MILE_W(4)) bus2 ();

    manual_drive_ctrl #(.MILE_W(4), .TICK_DIV(4), .BLINK_DIV(2), .REV_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    manual_drive_ctrl #(.MILE_W(4), .TICK_DIV(4), .BLINK_DIV(2), .REV_EN(0)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Phase is 1 out of reset and toggles every second edge.
    function automatic logic ph();
        return ((k / 2) % 2) == 0;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            if (rst) k = 0;
            else     k++;
        end
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        {bus.en, bus.power, bus.clutch, bus.brake, bus.throttle, bus.rgs, bus.left, bus.right} = '0;
        {bus2.en, bus2.power, bus2.clutch, bus2.brake, bus2.throttle, bus2.rgs, bus2.left, bus2.right} = '0;
        step(2);
        check("rst_state",   32'(bus.state), 32'h0);
        check("rst_moving",  32'(bus.moving_state), 32'h0);
        check("rst_pwroff",  32'(bus.power_off), 32'h0);
        check("rst_lights",  32'({bus.turn_left_light, bus.turn_right_light}), 32'h0);
        check("rst_mileage", 32'(bus.mileage), 32'h0);

        // Start up: throttle+clutch -> START, release clutch -> MOVING forward
        rst = 1'b0;
        bus.en = 1'b1; bus.power = 1'b1; bus.throttle = 1'b1; bus.clutch = 1'b1;
        step(1);                                                    // k=1
        check("start_state",  32'(bus.state), 32'h1);
        check("start_moving", 32'(bus.moving_state), 32'h0);
        bus.clutch = 1'b0;
        step(1);                                                    // k=2
        check("move_state",  32'(bus.state), 32'h2);
        check("move_moving", 32'(bus.moving_state), 32'h1);

        // Odometer: one increment per 4 MOVING cycles, wraps at 16
        step(60);                                                   // k=62
        check("mile_15", 32'(bus.mileage), 32'hf);
        check("fwd_lights", 32'({bus.turn_left_light, bus.turn_right_light}), 32'h0);
        step(4);                                                    // k=66
        check("mile_wrap", 32'(bus.mileage), 32'h0);
        step(4);                                                    // k=70
        check("mile_after_wrap", 32'(bus.mileage), 32'h1);
        check("fwd_pwroff", 32'(bus.power_off), 32'h0);

        // Right turn with blinking right lamp
        bus.right = 1'b1;
        step(1);                                                    // k=71
        check("right_moving", 32'(bus.moving_state), 32'h8);
        check("right_lamp",   32'(bus.turn_right_light), 32'(ph()));
        check("right_left_lamp", 32'(bus.turn_left_light), 32'h0);
        for (int i = 0; i < 4; i++) begin                           // k=72..75
            step(1);
            check("right_blink", 32'(bus.turn_right_light), 32'(ph()));
            check("right_blink_left", 32'(bus.turn_left_light), 32'h0);
        end

        // Reverse with clutch held: MOVE_BACK, lamps dark
        bus.rgs = 1'b1; bus.clutch = 1'b1;
        step(1);                                                    // k=76, phase 1
        check("back_moving", 32'(bus.moving_state), 32'h2);
        check("back_lights", 32'({bus.turn_left_light, bus.turn_right_light}), 32'h0);
        step(1);                                                    // k=77, phase 1
        check("back_lights2", 32'({bus.turn_left_light, bus.turn_right_light}), 32'h0);
        step(1);                                                    // k=78, mileage -> 3
        check("back_moving2", 32'(bus.moving_state), 32'h2);
        check("back_mileage", 32'(bus.mileage), 32'h3);

        // Reverse without clutch while moving: stall pulse, mileage kept
        bus.clutch = 1'b0; bus.throttle = 1'b0; bus.right = 1'b0;
        step(1);                                                    // k=79
        check("stall_pwroff",  32'(bus.power_off), 32'h1);
        check("stall_state",   32'(bus.state), 32'h0);
        check("stall_moving",  32'(bus.moving_state), 32'h0);
        check("stall_mileage", 32'(bus.mileage), 32'h3);
        step(1);                                                    // k=80, phase 1
        check("stall_pulse_end", 32'(bus.power_off), 32'h0);
        check("nstart_lights", 32'({bus.turn_left_light, bus.turn_right_light}), 32'h3);
        check("nstart_mileage", 32'(bus.mileage), 32'h3);

        // Drive back up to mileage 5, brake to NSTART
        bus.rgs = 1'b0; bus.throttle = 1'b1; bus.clutch = 1'b1;
        step(1);                                                    // k=81 START
        bus.clutch = 1'b0;
        step(1);                                                    // k=82 MOVING
        step(7);                                                    // k=89
        bus.brake = 1'b1;
        step(1);                                                    // k=90
        check("brake_state",   32'(bus.state), 32'h0);
        check("brake_mileage", 32'(bus.mileage), 32'h5);

        // NSTART stall: throttle without clutch clears the odometer
        bus.brake = 1'b0;
        step(1);                                                    // k=91
        check("nstall_pwroff",  32'(bus.power_off), 32'h1);
        check("nstall_mileage", 32'(bus.mileage), 32'h0);
        bus.throttle = 1'b0;
        step(1);                                                    // k=92
        check("nstall_pulse_end", 32'(bus.power_off), 32'h0);

        // Reach mileage 7 mid-count, then reset
        bus.throttle = 1'b1; bus.clutch = 1'b1;
        step(1);                                                    // START
        bus.clutch = 1'b0;
        step(1);                                                    // MOVING
        step(30);                                                   // 7 wraps + 2 residual ticks
        check("pre_rst_mileage", 32'(bus.mileage), 32'h7);
        rst = 1'b1;
        step(1);
        check("mrst_state",   32'(bus.state), 32'h0);
        check("mrst_moving",  32'(bus.moving_state), 32'h0);
        check("mrst_pwroff",  32'(bus.power_off), 32'h0);
        check("mrst_lights",  32'({bus.turn_left_light, bus.turn_right_light}), 32'h0);
        check("mrst_mileage", 32'(bus.mileage), 32'h0);

        // No residual tick: first increment needs a full 4 MOVING cycles
        rst = 1'b0; bus.clutch = 1'b1;
        step(1);
        check("post_rst_start", 32'(bus.state), 32'h1);
        bus.clutch = 1'b0;
        step(1);
        step(3);
        check("post_rst_mile0", 32'(bus.mileage), 32'h0);
        step(1);
        check("post_rst_mile1", 32'(bus.mileage), 32'h1);

        // Manual mode deselected: NSTART, mileage held
        bus.en = 1'b0;
        step(1);
        check("en_off_state",   32'(bus.state), 32'h0);
        check("en_off_moving",  32'(bus.moving_state), 32'h0);
        check("en_off_lights",  32'({bus.turn_left_light, bus.turn_right_light}), 32'h0);
        check("en_off_mileage", 32'(bus.mileage), 32'h1);

        // REV_EN=0 instance: reverse request from START is ignored
        bus2.en = 1'b1; bus2.power = 1'b1; bus2.throttle = 1'b1; bus2.clutch = 1'b1;
        step(1);
        check("norev_start", 32'(bus2.state), 32'h1);
        bus2.clutch = 1'b0; bus2.rgs = 1'b1;
        step(1);
        check("norev_stay",        32'(bus2.state), 32'h1);
        check("norev_stay_moving", 32'(bus2.moving_state), 32'h0);
        step(1);
        check("norev_stay2", 32'(bus2.state), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/manual_drive_ctrl.md
MANUAL_DRIVE_CTRL -- requirements
Module: manual_drive_ctrl

Interface
REQ-001 The block SHALL have parameter MILE_W, default 16, mileage counter width in bits (>=2).
REQ-002 The block SHALL have parameter TICK_DIV, default 100000000, clk cycles in MOVING per mileage increment (>=1).
REQ-003 The block SHALL have parameter BLINK_DIV, default 50000000, clk cycles per turn-light phase toggle (>=1).
REQ-004 The block SHALL have parameter REV_EN, default 1, reverse gear allowed (1) or forbidden (0).
REQ-005 The block SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 The block SHALL have port en, input, 1, manual mode selected by the global mode logic.
REQ-008 The block SHALL have port power, input, 1, vehicle power on.
REQ-009 The block SHALL have ports clutch, brake, throttle, rgs, left, right, each input, 1, driver controls; rgs selects reverse gear.
REQ-010 The block SHALL have port state, output, 2, run state: NSTART=00, START=01, MOVING=10.
REQ-011 The block SHALL have port moving_state, output, 4, motion: NON_MOVING=0000, MOVE_FORWARD=0001, MOVE_BACK=0010, TURN_LEFT=0100, TURN_RIGHT=1000.
REQ-012 The block SHALL have port power_off, output, 1, single-cycle power-off request pulse.
REQ-013 The block SHALL have ports turn_left_light and turn_right_light, each output, 1, lamp drives.
REQ-014 The block SHALL have port mileage, output, MILE_W, odometer count.

Function
REQ-015 All outputs SHALL be registered; inputs sampled at edge N take effect at edge N.
REQ-016 If ~en or ~power: state<=NSTART, moving_state<=NON_MOVING, lights 0, power_off 0, mileage held.
REQ-017 NSTART, first match wins: brake -> stay; throttle&~clutch -> stay, power_off=1 for one cycle, mileage and tick counter cleared; throttle&clutch&~rgs -> START; else stay. moving_state=NON_MOVING.
REQ-018 START, first match wins: brake -> NSTART; throttle&~clutch&rgs -> MOVING/MOVE_BACK if REV_EN=1, else stay START; throttle&~clutch&~rgs -> MOVING with direction per REQ-020; else stay START. moving_state=NON_MOVING while in START.
REQ-019 MOVING, first match wins: rgs&~clutch -> NSTART with power_off pulse (mileage kept); brake -> NSTART; ~throttle -> START; rgs&clutch -> MOVE_BACK if REV_EN=1, else hold current moving_state; else direction per REQ-020.
REQ-020 Direction: left only -> TURN_LEFT; right only -> TURN_RIGHT; none or both -> MOVE_FORWARD.
REQ-021 Blink phase register starts at 1, toggles every BLINK_DIV cycles, free-running.
REQ-022 Light request: NSTART (en&power) both; START/MOVING forward-type with left only -> left, right only -> right, both -> both, none -> neither; MOVE_BACK neither. Light = request & phase.
REQ-023 Tick counter increments each cycle state==MOVING, holds otherwise; at TICK_DIV-1 it returns to 0 and mileage increments.
REQ-024 Mileage SHALL wrap from 2^MILE_W-1 to 0 without flag.
REQ-025 Power-off clear and mileage tick in the same cycle: clear wins.

Reset
REQ-026 rst SHALL override all inputs: state=NSTART, moving_state=NON_MOVING, power_off=0, lights=0, mileage=0, tick counter=0, blink phase=1, blink counter=0.
REQ-027 Reset asserted mid-MOVING SHALL take effect at the next edge with no residual tick.

Verification (MILE_W=4, TICK_DIV=4, BLINK_DIV=2, REV_EN=1)
REQ-028 en=power=1, throttle=clutch=1 one cycle -> state=01; then clutch=0 -> state=10, moving_state=0001.
REQ-029 MOVING 64 cycles, controls steady -> mileage=0 after wrap (16 increments); 4 more -> mileage=1.
REQ-030 MOVING, right=1 -> moving_state=1000, turn_right_light toggles every 2 cycles, left light 0; rgs&clutch -> 0010, both lights 0.
REQ-031 MOVING, rgs=1, clutch=0 -> power_off=1 exactly one cycle, state=00, mileage unchanged.
REQ-032 NSTART, mileage=5, throttle=1, clutch=0 -> power_off pulse, mileage=0; REV_EN=0 build: START, throttle&rgs&~clutch -> remains 01.
REQ-033 rst pulse during MOVING with mileage=7 -> next cycle all outputs at REQ-026 values.
